// File: rtl/riscv_alu_bist_if.sv
// Operand/control bus between the ALU self-test sequencer and the ALU it exercises.
// master = sequencer side, slave = ALU / surrounding test logic.
interface riscv_alu_bist_if #(
    parameter int XLEN = 32
);
    logic            i_start;
    logic            o_busy;
    logic            o_done;
    logic            o_pass;
    logic [31:0]     o_signature;
    logic [XLEN-1:0] o_alu_a;
    logic [XLEN-1:0] o_alu_b;
    logic [3:0]      o_alu_ctrl;
    logic            o_zero_condition;
    logic [XLEN-1:0] i_alu_result;
    logic            i_zero_e;

    modport master (
        input  i_start, i_alu_result, i_zero_e,
        output o_busy, o_done, o_pass, o_signature,
        output o_alu_a, o_alu_b, o_alu_ctrl, o_zero_condition
    );

    modport slave (
        output i_start, i_alu_result, i_zero_e,
        input  o_busy, o_done, o_pass, o_signature,
        input  o_alu_a, o_alu_b, o_alu_ctrl, o_zero_condition
    );
endinterface

// File: rtl/riscv_alu_bist.sv
// ALU self-test sequencer: walks all ALU ops with LFSR operands, folds results into a MISR.
// Latency: done pulse 20*P_NVEC+1 cycles after start. No backpressure; ALU path must be combinational.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALU_CTRL_ADD
`define ALU_CTRL_ADD  4'h0
`define ALU_CTRL_SUB  4'h1
`define ALU_CTRL_XOR  4'h2
`define ALU_CTRL_OR   4'h3
`define ALU_CTRL_AND  4'h4
`define ALU_CTRL_SLL  4'h5
`define ALU_CTRL_SRL  4'h6
`define ALU_CTRL_SRA  4'h7
`define ALU_CTRL_SLT  4'h8
`define ALU_CTRL_SLTU 4'h9
`endif

module riscv_alu_bist #(
    parameter int unsigned P_NVEC   = 16,
    parameter logic [31:0] P_SEED   = 32'hACE1_2468,
    parameter logic [31:0] P_GOLDEN = 32'h0000_0000
) (
    input logic              i_clk,
    input logic              i_rst,
    riscv_alu_bist_if.master bus
);
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [7:0]  LAST_VEC  = 8'(P_NVEC - 1);
    localparam logic [3:0]  LAST_OP   = 4'd9;

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, FINISH} state_t;

    state_t           state, state_nxt;
    logic [31:0]      lfsr, lfsr_nxt;
    logic [31:0]      sig, sig_nxt;
    logic [7:0]       vec_cnt, vec_nxt;
    logic [3:0]       op_idx, op_nxt;
    logic             last_vec, last_all;
    logic             busy, done;
    logic [`XLEN-1:0] alu_a, alu_b;
    logic [3:0]       alu_ctrl;
    logic             zero_cond;
    logic             pass;

    function automatic logic [3:0] op_code(input logic [3:0] idx);
        case (idx)
            4'd0:    return `ALU_CTRL_ADD;
            4'd1:    return `ALU_CTRL_SUB;
            4'd2:    return `ALU_CTRL_XOR;
            4'd3:    return `ALU_CTRL_OR;
            4'd4:    return `ALU_CTRL_AND;
            4'd5:    return `ALU_CTRL_SLL;
            4'd6:    return `ALU_CTRL_SRL;
            4'd7:    return `ALU_CTRL_SRA;
            4'd8:    return `ALU_CTRL_SLT;
            4'd9:    return `ALU_CTRL_SLTU;
            default: return `ALU_CTRL_ADD;
        endcase
    endfunction

    function automatic logic [31:0] rotl13(input logic [31:0] x);
        return {x[18:0], x[31:19]};
    endfunction

    assign last_vec = (vec_cnt == LAST_VEC);
    assign last_all = last_vec && (op_idx == LAST_OP);
    assign vec_nxt  = last_vec ? 8'd0 : vec_cnt + 8'd1;
    assign op_nxt   = last_all ? 4'd0 : (last_vec ? op_idx + 4'd1 : op_idx);
    assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
    assign sig_nxt  = {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]}
                    ^ bus.i_alu_result[31:0] ^ {31'b0, bus.i_zero_e};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    if (bus.i_start) state_nxt = DRIVE;
            DRIVE: begin
                busy      = 1'b1;
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                busy      = 1'b1;
                state_nxt = last_all ? FINISH : DRIVE;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lfsr      <= P_SEED;
            sig       <= 32'hFFFF_FFFF;
            vec_cnt   <= 8'd0;
            op_idx    <= 4'd0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= `ALU_CTRL_ADD;
            zero_cond <= 1'b0;
            pass      <= 1'b0;
        end else begin
            if (state == IDLE && bus.i_start) begin
                lfsr      <= P_SEED;
                sig       <= 32'hFFFF_FFFF;
                vec_cnt   <= 8'd0;
                op_idx    <= 4'd0;
                alu_a     <= `XLEN'(P_SEED);
                alu_b     <= `XLEN'(rotl13(P_SEED));
                alu_ctrl  <= `ALU_CTRL_ADD;
                zero_cond <= 1'b0;
                pass      <= 1'b0;
            end
            if (state == CAPTURE) begin
                sig     <= sig_nxt;
                lfsr    <= lfsr_nxt;
                vec_cnt <= vec_nxt;
                op_idx  <= op_nxt;
                // Operands for the next vector come from the advanced LFSR; the last vector leaves them held.
                if (!last_all) begin
                    alu_a     <= `XLEN'(lfsr_nxt);
                    alu_b     <= `XLEN'(rotl13(lfsr_nxt));
                    alu_ctrl  <= op_code(op_nxt);
                    zero_cond <= vec_nxt[0];
                end
            end
            if (state == FINISH) pass <= (sig == P_GOLDEN);
        end
    end

    assign bus.o_busy           = busy;
    assign bus.o_done           = done;
    assign bus.o_pass           = pass;
    assign bus.o_signature      = sig;
    assign bus.o_alu_a          = alu_a;
    assign bus.o_alu_b          = alu_b;
    assign bus.o_alu_ctrl       = alu_ctrl;
    assign bus.o_zero_condition = zero_cond;
endmodule
